// File: rtl/module_booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: steps an external datapath through
// load, N add/sub-evaluate + arithmetic-shift iterations, then holds the result until acknowledged.
module module_booth_ctrl #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [1:0]             q_pair_i,
  input  logic                   ack_i,
  output logic                   ready_o,
  output logic                   load_o,
  output logic                   add_o,
  output logic                   sub_o,
  output logic                   shift_o,
  output logic                   done_o,
  output logic [$clog2(N+1)-1:0] iter_o
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic   [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      // Counter only moves on LOAD and SHIFT, and never goes below zero.
      if (state == LOAD) begin
        count <= CW'(N);
      end else if (state == SHIFT && count != '0) begin
        count <= count - CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    load_o     = 1'b0;
    add_o      = 1'b0;
    sub_o      = 1'b0;
    shift_o    = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_next = LOAD;
      end
      LOAD: begin
        load_o     = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        add_o      = (q_pair_i == 2'b01);
        sub_o      = (q_pair_i == 2'b10);
        state_next = SHIFT;
      end
      SHIFT: begin
        shift_o    = 1'b1;
        state_next = (count <= CW'(1)) ? DONE : EVAL;
      end
      DONE: begin
        done_o = 1'b1;
        if (ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign iter_o = count;

endmodule

// File: tb/tb_module_booth_ctrl.sv
// Self-checking bench for module_booth_ctrl: directed tables/sequences on N=1 and N=8
// instances, then randomized traffic against a phase-count reference model.
module tb_module_booth_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;

  logic       start8 = 1'b0, ack8 = 1'b0;
  logic [1:0] q8 = 2'b00;
  logic       ready8, load8, add8, sub8, shift8, done8;
  logic [3:0] iter8;

  logic       start1 = 1'b0, ack1 = 1'b0;
  logic [1:0] q1 = 2'b00;
  logic       ready1, load1, add1, sub1, shift1, done1;
  logic [0:0] iter1;

  always #5 clk = ~clk;

  module_booth_ctrl #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start_i(start8), .q_pair_i(q8), .ack_i(ack8),
    .ready_o(ready8), .load_o(load8), .add_o(add8), .sub_o(sub8),
    .shift_o(shift8), .done_o(done8), .iter_o(iter8)
  );

  module_booth_ctrl #(.N(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .q_pair_i(q1), .ack_i(ack1),
    .ready_o(ready1), .load_o(load1), .add_o(add1), .sub_o(sub1),
    .shift_o(shift1), .done_o(done1), .iter_o(iter1)
  );

  typedef struct {
    logic       start;
    logic       ack;
    logic [1:0] q;
    logic [6:0] expv;  // {ready, load, add, sub, shift, done, iter}
  } vec_t;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs from the number of edges elapsed since the start was accepted.
  function automatic logic [9:0] model_out(input int n, input bit busy, input int c,
                                           input logic [1:0] q);
    logic [9:0] r;
    int j;
    r = '0;
    if (!busy) begin
      r[9] = 1'b1;
    end else if (c == 0) begin
      r[8] = 1'b1;
    end else if (c <= 2 * n) begin
      j = (c + 1) / 2;
      r[3:0] = 4'(n - (j - 1));
      if (c % 2 == 1) begin
        r[7] = (q == 2'b01);
        r[6] = (q == 2'b10);
      end else begin
        r[5] = 1'b1;
      end
    end else begin
      r[4] = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_step(input int n, input logic start, input logic ack,
                                     inout bit busy, inout int c);
    if (!busy) begin
      if (start) begin
        busy = 1'b1;
        c = 0;
      end
    end else if (c >= 2 * n + 1) begin
      if (ack) busy = 1'b0;
    end else begin
      c++;
    end
  endfunction

  initial begin
    vec_t tbl[12];
    int   loads, shifts, addsub, early, strobes;
    bit   busy8, busy1;
    int   c8, c1;
    logic rst_now;

    tbl[0]  = '{1'b1, 1'b0, 2'b00, 7'b0100000};
    tbl[1]  = '{1'b0, 1'b0, 2'b01, 7'b0010001};
    tbl[2]  = '{1'b0, 1'b0, 2'b10, 7'b0000101};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 7'b0000010};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 7'b0000010};
    tbl[5]  = '{1'b0, 1'b1, 2'b00, 7'b1000000};
    tbl[6]  = '{1'b1, 1'b0, 2'b10, 7'b0100000};
    tbl[7]  = '{1'b0, 1'b0, 2'b10, 7'b0001001};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 7'b0000101};
    tbl[9]  = '{1'b0, 1'b1, 2'b00, 7'b0000010};
    tbl[10] = '{1'b0, 1'b1, 2'b00, 7'b1000000};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 7'b1000000};

    // Reset values, no clock edge yet
    #1;
    check("rst_out8", {ready8, load8, add8, sub8, shift8, done8, iter8}, 10'b1000000000);
    check("rst_out1", {ready1, load1, add1, sub1, shift1, done1, iter1}, 7'b1000000);
    @(negedge clk);
    rst = 1'b0;

    // N=1 table
    for (int i = 0; i < 12; i++) begin
      start1 = tbl[i].start;
      ack1   = tbl[i].ack;
      q1     = tbl[i].q;
      tick();
      check($sformatf("tbl_n1[%0d]", i),
            {ready1, load1, add1, sub1, shift1, done1, iter1}, tbl[i].expv);
    end
    start1 = 1'b0; ack1 = 1'b0; q1 = 2'b00;

    // Nominal N=8, q held 00
    start8 = 1'b1; q8 = 2'b00;
    tick();
    check("nom_load", load8, 1);
    start8 = 1'b0;
    shifts = 0; addsub = 0; early = 0; loads = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      shifts += shift8; addsub += add8 + sub8; early += done8; loads += load8;
    end
    check("nom_shifts", shifts, 8);
    check("nom_addsub", addsub, 0);
    check("nom_early_done", early, 0);
    check("nom_extra_load", loads, 0);
    tick();
    check("nom_done17", done8, 1);
    check("nom_iter_done", iter8, 0);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("nom_ready", ready8, 1);

    // Booth decode on successive EVAL cycles
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      q8 = 2'(i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : 0);
      #1;
      check($sformatf("dec_add[%0d]", i), add8, (i == 0) ? 1 : 0);
      check($sformatf("dec_sub[%0d]", i), sub8, (i == 1) ? 1 : 0);
      check($sformatf("dec_iter[%0d]", i), iter8, 8 - i);
      tick();
      tick();
    end
    q8 = 2'b00;
    for (int i = 0; i < 20 && !done8; i++) tick();
    check("dec_done", done8, 1);

    // Handshake hold and ignored start with start held high
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    start8 = 1'b1;
    loads = 0;
    for (int e = 0; e <= 17; e++) begin
      tick();
      loads += load8;
    end
    check("hs_done", done8, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      loads += load8;
      check($sformatf("hs_hold_done[%0d]", i), done8, 1);
      check($sformatf("hs_hold_iter[%0d]", i), iter8, 0);
    end
    check("ign_one_load", loads, 1);
    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("hs_ready", ready8, 1);
    tick();
    check("ign_reload", load8, 1);
    start8 = 1'b0;

    // Reset asserted between edges while in SHIFT
    tick(); tick();
    check("mid_in_shift", shift8, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", {ready8, load8, add8, sub8, shift8, done8, iter8}, 10'b1000000000);
    rst = 1'b0;
    start8 = 1'b1;
    tick();
    check("post_rst_start", load8, 1);
    start8 = 1'b0;
    tick();
    rst = 1'b1;
    #1 rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      strobes += load8 + add8 + sub8 + shift8 + done8;
    end
    check("abort_quiet", strobes, 0);
    check("abort_ready", ready8, 1);

    // Randomized traffic against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy8 = 1'b0; busy1 = 1'b0; c8 = 0; c1 = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      start8 = ($urandom_range(99) < 30);
      ack8   = ($urandom_range(99) < 40);
      q8     = 2'($urandom_range(3));
      start1 = ($urandom_range(99) < 30);
      ack1   = ($urandom_range(99) < 40);
      q1     = 2'($urandom_range(3));
      rst_now = ($urandom_range(299) == 0);
      if (rst_now) rst = 1'b1;
      if (rst_now) begin
        busy8 = 1'b0; busy1 = 1'b0;
      end else begin
        model_step(8, start8, ack8, busy8, c8);
        model_step(1, start1, ack1, busy1, c1);
      end
      tick();
      rst = 1'b0;
      #1;
      check($sformatf("rnd8[%0d]", cyc),
            {ready8, load8, add8, sub8, shift8, done8, iter8}, model_out(8, busy8, c8, q8));
      check($sformatf("rnd1[%0d]", cyc),
            {ready1, load1, add1, sub1, shift1, done1, 4'(iter1)}, model_out(1, busy1, c1, q1));
      check($sformatf("rnd_excl[%0d]", cyc), (add8 & sub8) | (add1 & sub1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
